// File: rtl/mips_decode_pkg.sv
// Shared constants for the MIPS decode stage: immediate modes and field slices.
package mips_decode_pkg;

    // Immediate extension modes carried alongside each instruction
    localparam logic [1:0] EXT_ZERO16 = 2'd0;
    localparam logic [1:0] EXT_SIGN16 = 2'd1;
    localparam logic [1:0] EXT_LUI    = 2'd2;
    localparam logic [1:0] EXT_JUMP26 = 2'd3;

    // Instruction field positions (R/I/J formats)
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int IMM16_W = 16;
    localparam int IMM26_W = 26;

endpackage

// File: rtl/regfile_2w2r.sv
// Register file with two write ports (WB has priority over NI) and two
// combinational read ports that see same-cycle writes (write-through bypass).
// r0 and addresses beyond NREG read as zero and ignore writes.
module regfile_2w2r #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ni_we,
    input  logic [RA_W-1:0] ni_addr,
    input  logic [XLEN-1:0] ni_data,
    output logic            ni_ack,
    input  logic [RA_W-1:0] ra1,
    input  logic [RA_W-1:0] ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs_r [NREG];
    logic            wb_commit_s;
    logic            ni_commit_s;

    // An address names a real, writable register (not r0, inside NREG)
    function automatic logic addr_ok(input logic [RA_W-1:0] a);
        return (a != {RA_W{1'b0}}) && (int'(a) < NREG);
    endfunction

    // NI is acked unless WB targets the same address this cycle; an acked
    // write to r0 or an out-of-range address is consumed but has no effect
    always_comb begin
        ni_ack      = ni_we & ~(wb_we & (wb_addr == ni_addr));
        wb_commit_s = wb_we & addr_ok(wb_addr);
        ni_commit_s = ni_ack & addr_ok(ni_addr);
    end

    // Storage update: both ports may commit in one cycle at distinct addresses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (wb_commit_s) begin
                regs_r[wb_addr] <= wb_data;
            end
            if (ni_commit_s) begin
                regs_r[ni_addr] <= ni_data;
            end
        end
    end

    // Read ports with bypass: a committing write is visible in the same cycle
    always_comb begin
        rd1 = {XLEN{1'b0}};
        rd2 = {XLEN{1'b0}};
        if (!addr_ok(ra1)) begin
            rd1 = {XLEN{1'b0}};
        end else if (wb_commit_s && (wb_addr == ra1)) begin
            rd1 = wb_data;
        end else if (ni_commit_s && (ni_addr == ra1)) begin
            rd1 = ni_data;
        end else begin
            rd1 = regs_r[ra1];
        end
        if (!addr_ok(ra2)) begin
            rd2 = {XLEN{1'b0}};
        end else if (wb_commit_s && (wb_addr == ra2)) begin
            rd2 = wb_data;
        end else if (ni_commit_s && (ni_addr == ra2)) begin
            rd2 = ni_data;
        end else begin
            rd2 = regs_r[ra2];
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: register-file read, immediate extension and a registered
// ID/EX stage with valid/ready handshake. While the output is stalled the
// held operands track writes to their source registers.
module decode_stage_pipe
    import mips_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [1:0]      ext_mode,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ni_we,
    input  logic [RA_W-1:0] ni_addr,
    input  logic [XLEN-1:0] ni_data,
    output logic            ni_ack,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [RA_W-1:0] out_rs,
    output logic [RA_W-1:0] out_rt,
    output logic [RA_W-1:0] out_rd_addr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm
);

    logic            out_valid_r;
    logic [XLEN-1:0] out_rd1_r;
    logic [XLEN-1:0] out_rd2_r;
    logic [RA_W-1:0] out_rs_r;
    logic [RA_W-1:0] out_rt_r;
    logic [RA_W-1:0] out_rd_addr_r;
    logic [XLEN-1:0] out_pc_r;
    logic [XLEN-1:0] out_imm_r;

    logic            capture_s;
    logic            hold_s;
    logic [RA_W-1:0] in_rs_s;
    logic [RA_W-1:0] in_rt_s;
    logic [RA_W-1:0] in_rd_s;
    logic [RA_W-1:0] ra1_s;
    logic [RA_W-1:0] ra2_s;
    logic [XLEN-1:0] rf_rd1_s;
    logic [XLEN-1:0] rf_rd2_s;
    logic [31:0]     lui32_s;
    logic [XLEN-1:0] imm_s;

    // Handshake decode and field extraction; read ports look at the incoming
    // instruction on capture, otherwise at the held rs/rt for refresh
    always_comb begin
        in_ready  = ~out_valid_r | out_ready;
        capture_s = in_valid & in_ready & ~flush;
        hold_s    = out_valid_r & ~out_ready;
        in_rs_s   = RA_W'(in_instr[RS_HI:RS_LO]);
        in_rt_s   = RA_W'(in_instr[RT_HI:RT_LO]);
        in_rd_s   = RA_W'(in_instr[RD_HI:RD_LO]);
        if (capture_s) begin
            ra1_s = in_rs_s;
            ra2_s = in_rt_s;
        end else begin
            ra1_s = out_rs_r;
            ra2_s = out_rt_r;
        end
    end

    // Immediate extension to XLEN; LUI places imm16 high and sign-extends the 32-bit result
    always_comb begin
        lui32_s = {in_instr[IMM16_W-1:0], 16'h0000};
        case (ext_mode)
            EXT_ZERO16: imm_s = XLEN'(in_instr[IMM16_W-1:0]);
            EXT_SIGN16: imm_s = XLEN'($signed(in_instr[IMM16_W-1:0]));
            EXT_LUI:    imm_s = XLEN'($signed(lui32_s));
            EXT_JUMP26: imm_s = XLEN'(in_instr[IMM26_W-1:0]);
            default:    imm_s = {XLEN{1'b0}};
        endcase
    end

    regfile_2w2r #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RA_W (RA_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ni_we   (ni_we),
        .ni_addr (ni_addr),
        .ni_data (ni_data),
        .ni_ack  (ni_ack),
        .ra1     (ra1_s),
        .ra2     (ra2_s),
        .rd1     (rf_rd1_s),
        .rd2     (rf_rd2_s)
    );

    // ID/EX register: flush beats capture, capture beats hold; a held entry
    // re-reads its operands through the bypass so writes land on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_rd1_r     <= {XLEN{1'b0}};
            out_rd2_r     <= {XLEN{1'b0}};
            out_rs_r      <= {RA_W{1'b0}};
            out_rt_r      <= {RA_W{1'b0}};
            out_rd_addr_r <= {RA_W{1'b0}};
            out_pc_r      <= {XLEN{1'b0}};
            out_imm_r     <= {XLEN{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (capture_s) begin
            out_valid_r   <= 1'b1;
            out_rd1_r     <= rf_rd1_s;
            out_rd2_r     <= rf_rd2_s;
            out_rs_r      <= in_rs_s;
            out_rt_r      <= in_rt_s;
            out_rd_addr_r <= in_rd_s;
            out_pc_r      <= in_pc;
            out_imm_r     <= imm_s;
        end else if (hold_s) begin
            out_rd1_r <= rf_rd1_s;
            out_rd2_r <= rf_rd2_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_rd1     = out_rd1_r;
    assign out_rd2     = out_rd2_r;
    assign out_rs      = out_rs_r;
    assign out_rt      = out_rt_r;
    assign out_rd_addr = out_rd_addr_r;
    assign out_pc      = out_pc_r;
    assign out_imm     = out_imm_r;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a vector table for decode/immediate
// cases plus hand-written sequences for bypass, refresh, write-port
// arbitration, r0, flush and reset.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [1:0]  ext_mode;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ni_we;
    logic [4:0]  ni_addr;
    logic [31:0] ni_data;
    logic        ni_ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd1;
    logic [31:0] out_rd2;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_pc;
    logic [31:0] out_imm;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  mode;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [4:0]  e_rd;
        logic [31:0] e_imm;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(32), .NREG(32), .RA_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .ext_mode    (ext_mode),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ni_we       (ni_we),
        .ni_addr     (ni_addr),
        .ni_data     (ni_data),
        .ni_ack      (ni_ack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd1     (out_rd1),
        .out_rd2     (out_rd2),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_rd_addr (out_rd_addr),
        .out_pc      (out_pc),
        .out_imm     (out_imm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock edge; inputs are driven and outputs sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_we    = 1'b0;
        ni_we    = 1'b0;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [1:0] mode);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        ext_mode = mode;
    endtask

    initial begin
        vecs[0] = '{32'h012A4020, 32'h0000_0100, 2'd0, 32'd5, 32'd7, 5'd8,  32'h0000_4020};
        vecs[1] = '{32'h0000_8001, 32'h0000_0104, 2'd0, 32'd0, 32'd0, 5'd16, 32'h0000_8001};
        vecs[2] = '{32'h0000_8001, 32'h0000_0108, 2'd1, 32'd0, 32'd0, 5'd16, 32'hFFFF_8001};
        vecs[3] = '{32'h0000_8001, 32'h0000_010C, 2'd2, 32'd0, 32'd0, 5'd16, 32'h8001_0000};
        vecs[4] = '{32'h0000_8001, 32'h0000_0110, 2'd3, 32'd0, 32'd0, 5'd16, 32'h0000_8001};

        rst = 1'b1; in_instr = 32'h0; in_pc = 32'h0; ext_mode = 2'd0;
        wb_addr = 5'd0; wb_data = 32'h0; ni_addr = 5'd0; ni_data = 32'h0;
        out_ready = 1'b1;
        idle();
        step();
        step();
        chk("reset_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_rd1", out_rd1, 32'h0);
        chk("reset_pc", out_pc, 32'h0);
        rst = 1'b0;

        // Preload r9=5, r10=7 through WB
        wb_we = 1'b1; wb_addr = 5'd9;  wb_data = 32'd5; step();
        wb_addr = 5'd10; wb_data = 32'd7; step();
        idle();

        // Vector table: one capture per entry, checked one edge later
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].instr, vecs[i].pc, vecs[i].mode);
            step();
            chk($sformatf("v%0d_valid", i), {31'h0, out_valid}, 32'h1);
            chk($sformatf("v%0d_rd1", i), out_rd1, vecs[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), out_rd2, vecs[i].e_rd2);
            chk($sformatf("v%0d_rdaddr", i), {27'h0, out_rd_addr}, {27'h0, vecs[i].e_rd});
            chk($sformatf("v%0d_imm", i), out_imm, vecs[i].e_imm);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
        end
        idle();
        step();
        chk("drain_valid", {31'h0, out_valid}, 32'h0);

        // Same-cycle bypass on capture, then refresh while stalled
        out_ready = 1'b0;
        send(32'h012A4020, 32'h0000_0200, 2'd0);
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_00AA;
        step();
        chk("bypass_rd1", out_rd1, 32'h0000_00AA);
        chk("bypass_rd2", out_rd2, 32'd7);
        wb_we = 1'b0;
        send(32'h0000_0000, 32'h0000_0999, 2'd0);
        #1;
        chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
        step();
        chk("stall_pc_kept", out_pc, 32'h0000_0200);
        in_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_00BB;
        step();
        wb_we = 1'b0;
        chk("refresh_rd1", out_rd1, 32'h0000_00BB);
        chk("refresh_pc", out_pc, 32'h0000_0200);
        chk("refresh_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        step();
        chk("release_valid", {31'h0, out_valid}, 32'h0);

        // WB and NI collide on r4: WB wins, NI retries
        send(32'h0080_0000, 32'h0000_0300, 2'd0);
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0011;
        ni_we = 1'b1; ni_addr = 5'd4; ni_data = 32'h0000_0022;
        #1;
        chk("collide_ni_ack", {31'h0, ni_ack}, 32'h0);
        step();
        chk("collide_rd1", out_rd1, 32'h0000_0011);
        wb_we = 1'b0;
        #1;
        chk("retry_ni_ack", {31'h0, ni_ack}, 32'h1);
        step();
        ni_we = 1'b0;
        chk("retry_rd1", out_rd1, 32'h0000_0022);
        send(32'h0084_0000, 32'h0000_0308, 2'd0);
        step();
        chk("r4_stored_rd1", out_rd1, 32'h0000_0022);
        chk("r4_stored_rd2", out_rd2, 32'h0000_0022);

        // Distinct addresses commit together
        in_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_0066;
        ni_we = 1'b1; ni_addr = 5'd7; ni_data = 32'h0000_0077;
        #1;
        chk("dual_ni_ack", {31'h0, ni_ack}, 32'h1);
        step();
        idle();
        send(32'h00C7_0000, 32'h0000_0310, 2'd0);
        step();
        chk("dual_rd1", out_rd1, 32'h0000_0066);
        chk("dual_rd2", out_rd2, 32'h0000_0077);

        // r0 ignores writes from both ports
        send(32'h0000_0000, 32'h0000_0400, 2'd0);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_FFFF;
        step();
        chk("r0_wb_rd1", out_rd1, 32'h0);
        wb_we = 1'b0;
        ni_we = 1'b1; ni_addr = 5'd0; ni_data = 32'h0000_FFFF;
        #1;
        chk("r0_ni_ack", {31'h0, ni_ack}, 32'h1);
        step();
        ni_we = 1'b0;
        chk("r0_ni_rd1", out_rd1, 32'h0);
        chk("r0_ni_rd2", out_rd2, 32'h0);
        step();
        chk("r0_stored_rd1", out_rd1, 32'h0);
        idle();
        step();

        // Flush kills both the held and the incoming instruction
        out_ready = 1'b0;
        send(32'h012A4020, 32'h0000_0600, 2'd0);
        step();
        chk("pre_flush_valid", {31'h0, out_valid}, 32'h1);
        send(32'h012A4020, 32'h0000_0604, 2'd0);
        flush = 1'b1;
        step();
        chk("flush_valid", {31'h0, out_valid}, 32'h0);
        flush = 1'b0;
        send(32'h012A4020, 32'h0000_0608, 2'd0);
        step();
        in_valid = 1'b0;
        chk("post_flush_pc", out_pc, 32'h0000_0608);
        step();

        // Reset while holding clears outputs and register file
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_hold_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_hold_rd1", out_rd1, 32'h0);
        chk("rst_hold_pc", out_pc, 32'h0);
        chk("rst_hold_imm", out_imm, 32'h0);
        chk("rst_hold_rs", {27'h0, out_rs}, 32'h0);
        out_ready = 1'b1;
        send(32'h012A4020, 32'h0000_0700, 2'd0);
        step();
        idle();
        chk("rst_rf_rd1", out_rd1, 32'h0);
        chk("rst_rf_rd2", out_rd2, 32'h0);
        chk("rst_rf_valid", {31'h0, out_valid}, 32'h1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
